// File: rtl/centroid_sequencer.sv
// Weighted-centroid engine: accumulates NPTS (x, y, w) beats and divides both
// weighted sums by sum(w) with one shared restoring divider, rounding half-up.
module centroid_sequencer #(
  parameter int NPTS = 6,
  parameter int CW   = 8,
  parameter int WW   = 4,
  parameter int SW   = CW + WW + $clog2(NPTS),
  parameter int SMW  = $clog2(NPTS * ((1 << WW) - 1) + 1)
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic           start,
  input  logic           pt_valid,
  output logic           pt_ready,
  input  logic [CW-1:0]  pt_x,
  input  logic [CW-1:0]  pt_y,
  input  logic [WW-1:0]  pt_w,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [CW-1:0]  xc,
  output logic [CW-1:0]  yc,
  output logic [SMW-1:0] sumw
);
  localparam int CNTW = $clog2(NPTS + 1);
  localparam int ITW  = $clog2(SW + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DIVX  = 3'd3;
  localparam logic [2:0] S_DIVY  = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   sxw_q, sxw_d, syw_q, syw_d, sw_q, sw_d;
  logic [SW:0]     rem_q, rem_d;
  logic [SW-1:0]   quo_q, quo_d;
  logic [ITW-1:0]  it_q, it_d;
  logic [CW-1:0]   xr_q, xr_d;
  logic [CW-1:0]   xc_q, xc_d, yc_q, yc_d;
  logic [SMW-1:0]  sumw_q, sumw_d;
  logic            done_q, done_d, err_q, err_d;

  logic [CW+WW-1:0] px, py;
  logic [SW:0]      trial, dvs, rem_n;
  logic [SW-1:0]    quo_n;
  logic             ge, last_it;

  // Half-up rounding: bump the quotient when 2*rem >= divisor, clamp to CW bits.
  function automatic logic [CW-1:0] round_sat(input logic [SW-1:0] q,
                                              input logic [SW:0]   r,
                                              input logic [SW-1:0] d);
    logic        up;
    logic [SW:0] s;
    up = {r, 1'b0} >= {2'b00, d};
    s  = {1'b0, q} + {{SW{1'b0}}, up};
    if (s > (SW+1)'((1 << CW) - 1)) return {CW{1'b1}};
    return s[CW-1:0];
  endfunction

  always_comb begin
    px      = (CW+WW)'(pt_x) * (CW+WW)'(pt_w);
    py      = (CW+WW)'(pt_y) * (CW+WW)'(pt_w);
    trial   = {rem_q[SW-1:0], quo_q[SW-1]};
    dvs     = {1'b0, sw_q};
    ge      = trial >= dvs;
    rem_n   = ge ? trial - dvs : trial;
    quo_n   = {quo_q[SW-2:0], ge};
    last_it = it_q == ITW'(SW - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sxw_d   = sxw_q;
    syw_d   = syw_q;
    sw_d    = sw_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    it_d    = it_q;
    xr_d    = xr_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    sumw_d  = sumw_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sxw_d = '0;
        syw_d = '0;
        sw_d  = '0;
        cnt_d = '0;
        if (start) begin
          err_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (pt_valid) begin
          sxw_d = sxw_q + SW'(px);
          syw_d = syw_q + SW'(py);
          sw_d  = sw_q + SW'(pt_w);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNTW'(NPTS - 1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sw_q == '0) begin
          err_d   = 1'b1;
          xc_d    = '0;
          yc_d    = '0;
          sumw_d  = '0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          rem_d   = '0;
          quo_d   = sxw_q;
          it_d    = '0;
          state_d = S_DIVX;
        end
      end
      S_DIVX: begin
        rem_d = rem_n;
        quo_d = quo_n;
        it_d  = it_q + 1'b1;
        if (last_it) begin
          xr_d    = round_sat(quo_n, rem_n, sw_q);
          rem_d   = '0;
          quo_d   = syw_q;
          it_d    = '0;
          state_d = S_DIVY;
        end
      end
      S_DIVY: begin
        rem_d = rem_n;
        quo_d = quo_n;
        it_d  = it_q + 1'b1;
        // Results land on the edge into FIN so they are valid alongside done.
        if (last_it) begin
          xc_d    = xr_q;
          yc_d    = round_sat(quo_n, rem_n, sw_q);
          sumw_d  = sw_q[SMW-1:0];
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sxw_q   <= '0;
      syw_q   <= '0;
      sw_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      it_q    <= '0;
      xr_q    <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      sumw_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sxw_q   <= sxw_d;
      syw_q   <= syw_d;
      sw_q    <= sw_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      it_q    <= it_d;
      xr_q    <= xr_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      sumw_q  <= sumw_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pt_ready = state_q == S_ACCUM;
  assign busy     = state_q != S_IDLE;
  assign done     = done_q;
  assign err      = err_q;
  assign xc       = xc_q;
  assign yc       = yc_q;
  assign sumw     = sumw_q;

endmodule

// File: tb/tb_centroid_sequencer.sv
// Directed bench for centroid_sequencer: vector table of full runs plus
// hand-written backpressure, start-while-busy, start-in-FIN and reset cases.
module tb_centroid_sequencer;
  localparam int NP = 6;

  logic       clk = 1'b0;
  logic       RESET, start, pt_valid, pt_ready, busy, done, err;
  logic [7:0] pt_x, pt_y, xc, yc;
  logic [3:0] pt_w;
  logic [6:0] sumw;

  int ncmp = 0;
  int nerr = 0;
  int prev_xc = 0;
  int prev_yc = 0;

  typedef struct packed {
    logic [0:NP-1][7:0] x;
    logic [0:NP-1][7:0] y;
    logic [0:NP-1][3:0] w;
    logic [7:0]         exc;
    logic [7:0]         eyc;
    logic [6:0]         esw;
    logic               eerr;
    int                 elat;
  } vec_t;

  vec_t vecs[8];

  centroid_sequencer dut (
    .clk(clk), .RESET(RESET), .start(start), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_w(pt_w),
    .busy(busy), .done(done), .err(err), .xc(xc), .yc(yc), .sumw(sumw)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic [0:NP-1][7:0] x, input logic [0:NP-1][7:0] y,
                               input logic [0:NP-1][3:0] w, input logic [7:0] exc,
                               input logic [7:0] eyc, input logic [6:0] esw,
                               input logic eerr, input int elat);
    vec_t v;
    v.x = x; v.y = y; v.w = w;
    v.exc = exc; v.eyc = eyc; v.esw = esw; v.eerr = eerr; v.elat = elat;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the last accept.
  task automatic feed(input vec_t v, input bit bp, input bit poke);
    int  tries;
    bit  acc;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("err_cleared_on_start", int'(err), 0);
    chk("xc_held", int'(xc), prev_xc);
    chk("yc_held", int'(yc), prev_yc);
    for (int i = 0; i < NP; i++) begin
      tries = 0;
      do begin
        pt_x     = v.x[i];
        pt_y     = v.y[i];
        pt_w     = v.w[i];
        pt_valid = (bp && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
        start    = (poke && i == 3) ? 1'b1 : 1'b0;
        acc      = pt_valid && pt_ready;
        @(posedge clk); @(negedge clk);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) chk("beat_accept_timeout", tries, 0);
    end
    pt_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Latency counts clock edges from the accepting edge to the edge where done is sampled high.
  task automatic wait_done(input bit poke, output int lat);
    int n = 0;
    while (!done && n < 100) begin
      start = (poke && n == 20) ? 1'b1 : 1'b0;
      @(posedge clk); @(negedge clk);
      n++;
    end
    start = 1'b0;
    lat = done ? n + 1 : -1;
  endtask

  task automatic check_result(input vec_t v, input int lat, input string tag);
    chk({tag, "_latency"}, lat, v.elat);
    chk({tag, "_xc"}, int'(xc), int'(v.exc));
    chk({tag, "_yc"}, int'(yc), int'(v.eyc));
    chk({tag, "_sumw"}, int'(sumw), int'(v.esw));
    chk({tag, "_err"}, int'(err), int'(v.eerr));
    prev_xc = int'(v.exc);
    prev_yc = int'(v.eyc);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      if (done) cnt++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    int lat, nd;
    vecs[0] = mkv({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6},
                  {4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1}, 8'd35, 8'd1, 7'd6, 1'b0, 32);
    vecs[1] = mkv({8'd1, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9}, {8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd5},
                  {4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 8'd1, 8'd0, 7'd2, 1'b0, 32);
    vecs[2] = mkv({8'd1, 8'd0, 8'd0, 8'd7, 8'd7, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3},
                  {4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0}, 8'd0, 8'd0, 7'd3, 1'b0, 32);
    vecs[3] = mkv({6{8'd255}}, {6{8'd255}}, {6{4'd15}}, 8'd255, 8'd255, 7'd90, 1'b0, 32);
    vecs[4] = mkv({6{8'd100}}, {6{8'd200}}, {6{4'd0}}, 8'd0, 8'd0, 7'd0, 1'b1, 2);
    vecs[5] = mkv({8'd3, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd7, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
                  {4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 8'd4, 8'd5, 7'd3, 1'b0, 32);
    vecs[6] = mkv({8'd200, 8'd100, 8'd50, 8'd25, 8'd0, 8'd255},
                  {8'd0, 8'd255, 8'd128, 8'd64, 8'd32, 8'd16},
                  {4'd15, 4'd1, 4'd2, 4'd3, 4'd0, 4'd7}, 8'd181, 8'd29, 7'd28, 1'b0, 32);
    vecs[7] = mkv({8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0},
                  {4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 8'd8, 8'd6, 7'd2, 1'b0, 32);

    RESET = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    RESET = 1'b0;
    chk("rst_pt_ready", int'(pt_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_xc", int'(xc), 0);
    chk("rst_yc", int'(yc), 0);
    chk("rst_sumw", int'(sumw), 0);

    for (int t = 0; t < 8; t++) begin
      feed(vecs[t], 1'b0, 1'b0);
      wait_done(1'b0, lat);
      check_result(vecs[t], lat, $sformatf("vec%0d", t));
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d_done_one_cycle", t), int'(done), 0);
      chk($sformatf("vec%0d_idle_after_fin", t), int'(busy), 0);
      chk($sformatf("vec%0d_err_held", t), int'(err), int'(vecs[t].eerr));
    end

    // Random pt_valid gaps must not change the result.
    feed(vecs[6], 1'b1, 1'b0);
    wait_done(1'b0, lat);
    check_result(vecs[6], lat, "backpressure");
    @(posedge clk); @(negedge clk);

    // start pulsed in ACCUM and in DIVY: exactly one done for the run.
    feed(vecs[0], 1'b0, 1'b1);
    wait_done(1'b1, lat);
    check_result(vecs[0], lat, "poke");
    count_dones(40, nd);
    chk("poke_done_pulses", nd, 1);
    chk("poke_idle", int'(busy), 0);

    // start coincident with done is ignored; start in the next IDLE cycle is taken.
    feed(vecs[1], 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_result(vecs[1], lat, "fin_start");
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("fin_start_ignored", int'(busy), 0);
    feed(vecs[3], 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_result(vecs[3], lat, "after_fin");
    @(posedge clk); @(negedge clk);

    // Reset mid-DIVX discards the run and clears the outputs.
    feed(vecs[5], 1'b0, 1'b0);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("pre_reset_busy", int'(busy), 1);
    RESET = 1'b1;
    @(posedge clk); @(negedge clk);
    RESET = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pt_ready", int'(pt_ready), 0);
    chk("midrst_xc", int'(xc), 0);
    chk("midrst_yc", int'(yc), 0);
    chk("midrst_sumw", int'(sumw), 0);
    count_dones(40, nd);
    chk("midrst_no_done", nd, 0);
    prev_xc = 0;
    prev_yc = 0;
    feed(vecs[7], 1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_result(vecs[7], lat, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
